// File: rtl/wwm_pkg.sv
// rtl/wwm_pkg.sv - shared state encodings, field geometry and pixel helpers for the projectile block
package wwm_pkg;

    localparam logic [2:0] ST_IDLE   = 3'b001;
    localparam logic [2:0] ST_FLIGHT = 3'b010;
    localparam logic [2:0] ST_RESULT = 3'b100;

    typedef logic signed [11:0] coord_t;

    typedef struct packed {
        logic hit;
        logic miss;
    } verdict_t;

    // Target box and play-field limits, in screen pixels (+y is down)
    localparam coord_t TGT_X_MIN  = 12'sd650;
    localparam coord_t TGT_X_MAX  = 12'sd675;
    localparam coord_t TGT_Y_MIN  = 12'sd470;
    localparam coord_t TGT_Y_MAX  = 12'sd475;
    localparam coord_t FIELD_X_HI = 12'sd775;
    localparam coord_t FIELD_X_LO = 12'sd160;
    localparam coord_t FIELD_Y_HI = 12'sd475;
    localparam coord_t FIELD_Y_LO = 12'sd50;

    function automatic logic [9:0] clamp_pix(input coord_t v);
        if (v < 12'sd0) begin
            return 10'd0;
        end else if (v > 12'sd1023) begin
            return 10'd1023;
        end else begin
            return v[9:0];
        end
    endfunction

endpackage

// File: rtl/wwm_bounds_check.sv
// rtl/wwm_bounds_check.sv - combinational target/field classifier for a candidate position
module wwm_bounds_check
    import wwm_pkg::*;
(
    input  coord_t nx,
    input  coord_t ny,
    output logic   is_hit,
    output logic   is_out
);

    // Signed compares so positions that wrapped negative count as off-field
    always_comb begin
        is_hit = (nx >= TGT_X_MIN) && (nx <= TGT_X_MAX) &&
                 (ny >= TGT_Y_MIN) && (ny <= TGT_Y_MAX);
        is_out = (nx >= FIELD_X_HI) || (nx <= FIELD_X_LO) ||
                 (ny >= FIELD_Y_HI) || (ny <= FIELD_Y_LO);
    end

endmodule

// File: rtl/wwm_projectile_ctrl.sv
// rtl/wwm_projectile_ctrl.sv - one-shot projectile sequencer: launch, per-frame flight with gravity, hit/miss result
module wwm_projectile_ctrl
    import wwm_pkg::*;
#(
    parameter int VEL_SHIFT = 1,
    parameter int GRAV_DIV  = 4,
    parameter int VMAX      = 15,
    parameter int MAX_TICKS = 600
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       launch,
    input  logic [3:0] vX,
    input  logic [3:0] vY,
    input  logic [9:0] start_x,
    input  logic [9:0] start_y,
    input  logic       frame_tick,
    input  logic       ack,
    output logic [9:0] proj_x,
    output logic [9:0] proj_y,
    output logic       busy,
    output logic       result_valid,
    output logic       hit,
    output logic       miss
);

    localparam int TICK_W = $clog2(MAX_TICKS) + 1;
    localparam int GRAV_W = $clog2(GRAV_DIV) + 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MAX_TICKS - 1);
    localparam logic [GRAV_W-1:0] GRAV_LAST = GRAV_W'(GRAV_DIV - 1);
    localparam logic signed [7:0] VY_FLOOR = 8'(-VMAX);

    logic [2:0]              state_q, state_d;
    logic [9:0]              px_q, px_d;
    logic [9:0]              py_q, py_d;
    logic signed [7:0]       vx_q, vx_d;
    logic signed [7:0]       vy_q, vy_d;
    logic [TICK_W-1:0]       tick_q, tick_d;
    logic [GRAV_W-1:0]       grav_q, grav_d;
    verdict_t                verdict_q, verdict_d;

    coord_t            dx, dy, nx, ny;
    logic signed [7:0] vy_dec;
    logic              is_hit, is_out;

    always_comb begin
        dx     = {{4{vx_q[7]}}, vx_q} <<< VEL_SHIFT;
        dy     = {{4{vy_q[7]}}, vy_q} <<< VEL_SHIFT;
        nx     = {2'b00, px_q} + dx;
        ny     = {2'b00, py_q} - dy;
        vy_dec = (vy_q <= VY_FLOOR) ? VY_FLOOR : (vy_q - 8'sd1);
    end

    wwm_bounds_check u_bounds (
        .nx     (nx),
        .ny     (ny),
        .is_hit (is_hit),
        .is_out (is_out)
    );

    always_comb begin
        state_d   = state_q;
        px_d      = px_q;
        py_d      = py_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        tick_d    = tick_q;
        grav_d    = grav_q;
        verdict_d = verdict_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_FLIGHT;
                    px_d    = start_x;
                    py_d    = start_y;
                    vx_d    = {{4{vX[3]}}, vX};
                    vy_d    = {{4{vY[3]}}, vY};
                    tick_d  = '0;
                    grav_d  = '0;
                end
            end
            ST_FLIGHT: begin
                if (frame_tick) begin
                    px_d   = clamp_pix(nx);
                    py_d   = clamp_pix(ny);
                    tick_d = tick_q + 1'b1;
                    // Gravity lands after this tick's move, so position always uses the old vy
                    if (grav_q == GRAV_LAST) begin
                        grav_d = '0;
                        vy_d   = vy_dec;
                    end else begin
                        grav_d = grav_q + 1'b1;
                    end
                    if (is_hit) begin
                        state_d        = ST_RESULT;
                        verdict_d.hit  = 1'b1;
                    end else if (is_out || (tick_q == TICK_LAST)) begin
                        state_d        = ST_RESULT;
                        verdict_d.miss = 1'b1;
                    end
                end
            end
            ST_RESULT: begin
                if (ack) begin
                    state_d   = ST_IDLE;
                    verdict_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                verdict_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            px_q      <= '0;
            py_q      <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            tick_q    <= '0;
            grav_q    <= '0;
            verdict_q <= '0;
        end else begin
            state_q   <= state_d;
            px_q      <= px_d;
            py_q      <= py_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            tick_q    <= tick_d;
            grav_q    <= grav_d;
            verdict_q <= verdict_d;
        end
    end

    assign proj_x       = px_q;
    assign proj_y       = py_q;
    assign busy         = (state_q == ST_FLIGHT) || (state_q == ST_RESULT);
    assign result_valid = (state_q == ST_RESULT);
    assign hit          = verdict_q.hit;
    assign miss         = verdict_q.miss;

endmodule

// File: tb/tb_wwm_projectile_ctrl.sv
// tb/tb_wwm_projectile_ctrl.sv - scoreboard bench for wwm_projectile_ctrl with directed shots
module tb_wwm_projectile_ctrl;

    logic       clk;
    logic       Reset_n;
    logic       launch;
    logic [3:0] vX, vY;
    logic [9:0] start_x, start_y;
    logic       frame_tick;
    logic       ack;
    logic [9:0] proj_x, proj_y;
    logic       busy, result_valid, hit, miss;

    wwm_projectile_ctrl #(
        .VEL_SHIFT (1),
        .GRAV_DIV  (1),
        .VMAX      (15),
        .MAX_TICKS (12)
    ) dut (
        .clk          (clk),
        .Reset_n      (Reset_n),
        .launch       (launch),
        .vX           (vX),
        .vY           (vY),
        .start_x      (start_x),
        .start_y      (start_y),
        .frame_tick   (frame_tick),
        .ack          (ack),
        .proj_x       (proj_x),
        .proj_y       (proj_y),
        .busy         (busy),
        .result_valid (result_valid),
        .hit          (hit),
        .miss         (miss)
    );

    typedef struct {
        bit hit;
        bit miss;
        int x;
        int y;
        int ticks;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   ticks_sent = 0;
    int   ytab[5] = '{194, 190, 188, 188, 190};
    logic rv_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        ticks_sent++;
    endtask

    always @(negedge clk) begin
        if (result_valid && !rv_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hit", hit, e.hit);
                check("miss", miss, e.miss);
                check("hit_miss_excl", hit & miss, 0);
                check("result_x", proj_x, e.x);
                check("result_y", proj_y, e.y);
                check("result_ticks", ticks_sent, e.ticks);
            end
        end
        rv_prev <= result_valid;
    end

    task automatic run_shot(input int sx, input int sy, input int vx, input int vy,
                            input bit e_hit, input bit e_miss, input int ex, input int ey,
                            input int et, input bit poke, input bit trace);
        exp_t e;
        e = '{e_hit, e_miss, ex, ey, et};
        sb.push_back(e);
        start_x = 10'(sx);
        start_y = 10'(sy);
        vX      = 4'(vx);
        vY      = 4'(vy);
        launch  = 1'b1;
        step();
        launch  = 1'b0;
        check("busy_after_launch", busy, 1);
        ticks_sent = 0;
        while (result_valid !== 1'b1 && ticks_sent < 40) begin
            tick();
            if (trace && ticks_sent <= 5) check("traj_y", proj_y, ytab[ticks_sent-1]);
            if (poke && ticks_sent == 1 && result_valid !== 1'b1) begin
                launch  = 1'b1;
                ack     = 1'b1;
                start_x = 10'd0;
                start_y = 10'd0;
                step();
                launch  = 1'b0;
                ack     = 1'b0;
                step();
                check("flight_x_held", proj_x, 714);
                check("flight_y_held", proj_y, 300);
                check("flight_busy", busy, 1);
            end
            step();
            step();
        end
        check("result_reached", result_valid, 1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("result_hold_x", proj_x, ex);
        check("result_hold_y", proj_y, ey);
        check("result_hold_valid", result_valid, 1);
        ack    = 1'b1;
        launch = poke;
        step();
        ack    = 1'b0;
        launch = 1'b0;
        check("ack_busy", busy, 0);
        check("ack_valid", result_valid, 0);
        check("ack_hit", hit, 0);
        check("ack_miss", miss, 0);
        check("ack_proj_x", proj_x, ex);
        step();
        check("idle_after_ack", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        Reset_n    = 1'b0;
        launch     = 1'b0;
        vX         = '0;
        vY         = '0;
        start_x    = '0;
        start_y    = '0;
        frame_tick = 1'b0;
        ack        = 1'b0;
        repeat (3) step();
        Reset_n = 1'b1;
        step();
        check("rst_proj_x", proj_x, 0);
        check("rst_proj_y", proj_y, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_hit", hit, 0);
        check("rst_miss", miss, 0);

        frame_tick = 1'b1;
        ack        = 1'b1;
        step();
        frame_tick = 1'b0;
        ack        = 1'b0;
        check("idle_tick_busy", busy, 0);
        check("idle_tick_y", proj_y, 0);

        // Abort a flight with reset: nothing may be reported
        start_x = 10'd500;
        start_y = 10'd300;
        vX      = 4'd1;
        vY      = 4'd0;
        launch  = 1'b1;
        step();
        launch  = 1'b0;
        tick();
        step();
        tick();
        check("pre_reset_x", proj_x, 504);
        Reset_n = 1'b0;
        #1;
        check("midrst_proj_x", proj_x, 0);
        check("midrst_proj_y", proj_y, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", result_valid, 0);
        repeat (2) step();
        Reset_n = 1'b1;
        step();

        //        sx    sy   vx  vy  hit miss  ex    ey  ticks poke trace
        run_shot(170,  300, -5,  0, 0,  1,   160,  300, 1,   0,   0);
        run_shot(630,  454,  5, -4, 1,  0,   650,  472, 2,   0,   0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("idle_proj_held", proj_x, 650);
        run_shot(700,  300,  7,  0, 0,  1,   784,  330, 6,   1,   0);
        run_shot(400,   60,  0, -8, 0,  1,   400,  364, 12,  0,   0);
        run_shot(300,  200,  0,  3, 0,  1,   300,  260, 12,  0,   1);
        run_shot(1020,  10,  7,  7, 0,  1,  1023,    0, 1,   0,   0);
        run_shot(660,  467,  0, -4, 1,  0,   660,  475, 1,   0,   0);

        repeat (5) step();
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
